mc_control: RTL and testbench
=============================

// Module: mc_control
// PURPOSE
//  Multi-cycle MIPS-subset control unit; the initiator side of the ALU interface (drives alu_ctrl, consumes zero).
//  Decodes opcode/funct from the instruction register and sequences fetch/decode/execute/memory/writeback.
//  Emits datapath mux selects and write enables each cycle; sits between the IR and the shared datapath.
// PARAMETERS
//  OP_RTYPE  6'h00  R-type opcode (funct: 6'h20 add, 6'h22 sub, 6'h24 and, 6'h25 or)
//  OP_LW     6'h23  load word opcode
//  OP_SW     6'h2B  store word opcode
//  OP_BEQ    6'h04  branch-if-equal opcode
//  OP_ADDI   6'h08  add-immediate opcode
//  OP_J      6'h02  jump opcode
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous active-high reset
//  opcode      in   6   IR[31:26], stable from DECODE until instruction end
//  funct       in   6   IR[5:0]
//  zero        in   1   ALU zero flag, same cycle as alu_ctrl
//  alu_ctrl    out  3   ALU op: 000 add, 001 sub, 011 and, 100 or
//  alu_src_a   out  1   0=PC, 1=regA
//  alu_src_b   out  2   00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  pc_src      out  2   00=ALU result, 01=ALUOut, 10=jump target
//  pc_en       out  1   PC register write enable
//  iord        out  1   memory address: 0=PC, 1=ALUOut
//  mem_read    out  1   memory read strobe
//  mem_write   out  1   memory write strobe
//  ir_write    out  1   instruction register load
//  reg_dst     out  1   0=rt, 1=rd
//  mem_to_reg  out  1   0=ALUOut, 1=MDR
//  reg_write   out  1   register file write enable
//  instr_done  out  1   1-cycle pulse in last state of each instruction
//  instr_cnt   out  32  retired-instruction count
// BEHAVIOUR
//  - 4-bit state register; outputs Moore-decoded from state, except alu_ctrl (funct in EXEC) and pc_en (zero in BRANCH).
//  - Unlisted outputs are 0 in every state; alu_ctrl defaults to 000.
//  - rst=1: next state FETCH, instr_cnt<=0; while rst=1 all outputs forced 0, incl. pc_en and write strobes.
//    Reset mid-instruction abandons it; no instr_done, no count increment.
//  - FETCH: mem_read, ir_write, src_a=0, src_b=01, add, pc_src=00, pc_en=1 -> DECODE.
//  - DECODE: src_a=0, src_b=11, add (branch target to ALUOut). Next: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH,
//    ADDI->ADDIEXEC, J->JUMP, other->FETCH (NOP, instr_done=1).
//  - MEMADR: src_a=1, src_b=10, add -> MEMRD (LW) / MEMWR (SW).
//  - MEMRD: iord, mem_read -> MEMWB.   MEMWB: reg_dst=0, mem_to_reg=1, reg_write, done -> FETCH.
//  - MEMWR: iord, mem_write, done -> FETCH.
//  - EXEC: src_a=1, src_b=00, alu_ctrl by funct (unknown funct -> 000) -> RWB.
//  - RWB: reg_dst=1, mem_to_reg=0, reg_write, done -> FETCH.
//  - BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_en=zero, done -> FETCH.
//  - ADDIEXEC: src_a=1, src_b=10, add -> ADDIWB.   ADDIWB: reg_dst=0, reg_write, done -> FETCH.
//  - JUMP: pc_src=10, pc_en=1, done -> FETCH.
//  - Latency in cycles incl. FETCH: LW 5; SW, R-type, ADDI 4; BEQ, J 3; unknown opcode 2.
//  - instr_cnt increments by 1 on each instr_done; wraps 32'hFFFFFFFF -> 0.
//  - reg_write, mem_write and pc_en are never asserted together.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: extra output `illegal` (1 bit) and TRAP state. Unknown opcode in DECODE or unknown funct
//    in EXEC -> TRAP: illegal=1, all strobes 0, no instr_done, held until rst.
//  Undefined: no `illegal` port, no TRAP; unknown opcode = 2-cycle NOP; unknown funct executes as add.
// TESTING
//  1. rst held 3 cycles -> all outputs 0, instr_cnt=0; release -> FETCH with pc_en=1, mem_read=1, ir_write=1.
//  2. opcode 6'h23 -> 5 states FETCH..MEMWB; reg_write=1, mem_to_reg=1 only in 5th cycle; instr_cnt 0->1.
//  3. R-type funct 6'h22 -> alu_ctrl=001 in EXEC; 6'h25 -> 100; RWB reg_dst=1, reg_write=1.
//  4. opcode 6'h04 with zero=1 -> pc_en=1, pc_src=01 in cycle 3; repeat with zero=0 -> pc_en=0, done still pulses.
//  5. rst asserted in MEMRD of LW -> no reg_write, instr_cnt unchanged, next cycle after release is FETCH.
//  6. opcode 6'h3F -> NOP back to FETCH in 2 cycles (undefined); illegal=1 sticky until rst (ILLEGAL_TRAP_EN).

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Optional ILLEGAL_TRAP_EN adds an `illegal` output and a sticky TRAP state for unknown opcode/funct.
module mc_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [31:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_BRANCH, S_ADDIEXEC, S_ADDIWB, S_JUMP
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  funct_alu;
  logic        funct_known;

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_known = 1'b1;
    case (funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      default: funct_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      if (instr_done) cnt <= cnt + 32'd1;
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEXEC;
            OP_J:         state <= S_JUMP;
`ifdef ILLEGAL_TRAP_EN
            default:      state <= S_TRAP;
`else
            default:      state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state <= S_MEMWB;
`ifdef ILLEGAL_TRAP_EN
        S_EXEC:     state <= funct_known ? S_RWB : S_TRAP;
        S_TRAP:     state <= S_TRAP;
`else
        S_EXEC:     state <= S_RWB;
`endif
        S_ADDIEXEC: state <= S_ADDIWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode, except alu_ctrl in EXEC (funct) and pc_en in BRANCH (zero); rst blanks everything.
  always_comb begin
    alu_ctrl   = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_en     = 1'b1;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
          instr_done = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
`endif
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_ctrl  = funct_alu;
        end
        S_RWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = ALU_SUB;
          pc_src     = 2'b01;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        S_ADDIEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = 2'b10;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign instr_cnt = rst ? 32'd0 : cnt;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction cycle tables from the ISA rules, scoreboarded per cycle.
module tb_mc_control;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic        zero = 1'b0;
  logic [2:0]  alu_ctrl;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic        pc_en, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, instr_done;
  logic [31:0] instr_cnt;
  logic        illegal_s;

  int checks = 0;
  int errors = 0;
  logic [31:0] cnt_model = 32'd0;
  logic [17:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal_s),
`endif
    .instr_cnt(instr_cnt)
  );
`ifndef ILLEGAL_TRAP_EN
  assign illegal_s = 1'b0;
`endif

  wire [17:0] got_vec = {illegal_s, alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, iord,
                         mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  endfunction

  function automatic bit fn_known(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25};
  endfunction

  function automatic bit is_illegal(input logic [5:0] op, input logic [5:0] fn);
    return TRAP && (!op_known(op) || (op == 6'h00 && !fn_known(fn)));
  endfunction

  // Cycles before retirement (or before trapping for an illegal instruction).
  function automatic int ilen(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return 5;
      6'h2B, 6'h08: return 4;
      6'h00: return (TRAP && !fn_known(fn)) ? 3 : 4;
      6'h04, 6'h02: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control vector for cycle k (k=0 is FETCH) of an instruction.
  function automatic logic [17:0] exp_out(input logic [5:0] op, input logic [5:0] fn,
                                          input int k, input logic z);
    logic [2:0] alu = 3'b000;
    logic sa = 0, pe = 0, io = 0, mr = 0, mw = 0, iw = 0, rd = 0, mtr = 0, rw = 0, dn = 0, il = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    if (is_illegal(op, fn) && k >= ilen(op, fn)) il = 1;
    else if (k == 0) begin mr = 1; iw = 1; sb = 2'b01; pe = 1; end
    else if (k == 1) begin sb = 2'b11; dn = !op_known(op) && !TRAP; end
    else begin
      case (op)
        6'h23, 6'h2B: begin
          if (k == 2) begin sa = 1; sb = 2'b10; end
          else if (op == 6'h2B) begin io = 1; mw = 1; dn = 1; end
          else if (k == 3) begin io = 1; mr = 1; end
          else begin mtr = 1; rw = 1; dn = 1; end
        end
        6'h00: begin
          if (k == 2) begin
            sa = 1;
            case (fn)
              6'h22: alu = 3'b001;
              6'h24: alu = 3'b011;
              6'h25: alu = 3'b100;
              default: alu = 3'b000;
            endcase
          end else begin rd = 1; rw = 1; dn = 1; end
        end
        6'h04: begin sa = 1; alu = 3'b001; ps = 2'b01; pe = z; dn = 1; end
        6'h08: begin
          if (k == 2) begin sa = 1; sb = 2'b10; end
          else begin rw = 1; dn = 1; end
        end
        default: begin ps = 2'b10; pe = 1; dn = 1; end
      endcase
    end
    return {il, alu, sa, sb, ps, pe, io, mr, mw, iw, rd, mtr, rw, dn};
  endfunction

  // One reset cycle: outputs blank while rst is high, then FETCH after release.
  task automatic reset_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {14'd0, got_vec}, 32'd0);
    check("rst_cnt", instr_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_model = 32'd0;
  endtask

  // Driver: runs one instruction starting in FETCH. zmode 0/1 forces zero, 2 randomizes.
  // rst_at >= 0 asserts reset during that cycle instead of completing the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int rst_at);
    int n = ilen(op, fn);
    opcode = op;
    funct = fn;
    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin
        reset_cycle();
        return;
      end
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      exp_q.push_back(exp_out(op, fn, k, zero));
      @(negedge clk);
      check($sformatf("op%h_fn%h_c%0d", op, fn, k), {14'd0, got_vec}, {14'd0, exp_q.pop_front()});
      check("instr_cnt", instr_cnt, cnt_model);
      check("excl", 32'(reg_write) + 32'(mem_write) + 32'(pc_en) <= 1 ? 32'd1 : 32'd0, 32'd1);
      @(posedge clk); #1;
      if (exp_out(op, fn, k, zero) & 18'd1) cnt_model = cnt_model + 32'd1;
    end
    if (is_illegal(op, fn)) begin
      for (int t = 0; t < 3; t++) begin
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("trap_hold", {14'd0, got_vec}, {14'd0, exp_out(op, fn, n + t, zero)});
        check("trap_cnt", instr_cnt, cnt_model);
        @(posedge clk); #1;
      end
      reset_cycle();
    end
  endtask

  logic [5:0] op_tab[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  logic [5:0] fn_tab[4] = '{6'h20, 6'h22, 6'h24, 6'h25};

  initial begin
    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_outputs", {14'd0, got_vec}, 32'd0);
      check("rst_hold_cnt", instr_cnt, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // directed cases
    run_instr(6'h23, 6'h00, 2, -1);
    run_instr(6'h00, 6'h22, 2, -1);
    run_instr(6'h00, 6'h25, 2, -1);
    run_instr(6'h04, 6'h00, 1, -1);
    run_instr(6'h04, 6'h00, 0, -1);
    run_instr(6'h2B, 6'h00, 2, -1);
    run_instr(6'h08, 6'h00, 2, -1);
    run_instr(6'h02, 6'h00, 2, -1);
    run_instr(6'h23, 6'h00, 2, 3);
    run_instr(6'h00, 6'h24, 2, -1);
    run_instr(6'h3F, 6'h00, 2, -1);
    run_instr(6'h00, 6'h3F, 2, -1);
    run_instr(6'h02, 6'h00, 2, -1);

    // randomized instruction stream with occasional mid-instruction resets
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      int ra;
      int oi = $urandom_range(0, 6);
      int fi = $urandom_range(0, 4);
      if (oi < 6) op = op_tab[oi];
      else begin
        op = 6'($urandom_range(0, 63));
        while (op_known(op)) op = 6'($urandom_range(0, 63));
      end
      fn = (fi < 4) ? fn_tab[fi] : 6'($urandom_range(0, 63));
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, ilen(op, fn) - 1) : -1;
      run_instr(op, fn, 2, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
